neo_stream: RTL and testbench

NEO_STREAM -- requirements
Module: neo_stream

---
 rtl/neo_stream.sv | 213 +++++++++++++++++++++
 tb/tb_neo_stream.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/neo_stream.sv
// neo_stream -- streaming Nonlinear Energy Operator over a block of samples.
//
// Reads len signed samples x[0..len-1] from a source memory, computes
// psi[n] = x[n]^2 - x[n-1]*x[n+1] in full 2*N+1-bit precision, and writes one
// result per address to a destination memory (the two end addresses get 0).
// Results above a signed threshold are counted.
//
// Ports:
//   Clk        clock, rising edge
//   reset      asynchronous, active-low reset
//   start      launch request, sampled only while idle
//   len        number of samples (legal range 3..M), latched on start
//   thresh     signed spike threshold, latched on start
//   rdata      source sample, valid the cycle after ren
//   raddr/ren  source read address / enable
//   waddr/wen  destination write address / enable
//   wdata      NEO result, saturated when OW < 2*N+1
//   busy       run in progress (cycle after start until the last write)
//   done       one-cycle completion pulse
//   err        illegal length seen on the last accepted start
//   spike_cnt  number of results above thresh in the last run
module neo_stream #(
   parameter int N  = 8,
   parameter int M  = 16,
   parameter int OW = 2*N+1,
   localparam int AW = $clog2(M)
) (
   input  logic          Clk,
   input  logic          reset,
   input  logic          start,
   input  logic [AW:0]   len,
   input  logic [2*N:0]  thresh,
   input  logic [N-1:0]  rdata,
   output logic [AW-1:0] raddr,
   output logic          ren,
   output logic [AW-1:0] waddr,
   output logic [OW-1:0] wdata,
   output logic          wen,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [AW:0]   spike_cnt
);

   localparam int PW = 2*N+1;            // full-precision psi width
   localparam int CW = AW+3;             // run cycle counter, covers len+4
   localparam int SH = (OW < PW) ? OW-1 : PW-2;
   localparam logic signed [PW-1:0] SMAX = {{(PW-SH){1'b0}}, {SH{1'b1}}};
   localparam logic signed [PW-1:0] SMIN = {{(PW-SH){1'b1}}, {SH{1'b0}}};
   localparam logic [AW:0] LEN_MIN = (AW+1)'(3);
   localparam logic [AW:0] LEN_MAX = (AW+1)'(M);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                 state_r;
   logic [AW:0]            len_r;
   logic signed [PW-1:0]   thresh_r;
   logic [CW-1:0]          cyc_r;        // cycle number within the run
   logic                   rvalid_r;     // rdata carries a requested sample
   logic signed [N-1:0]    x_prev_r;
   logic signed [N-1:0]    x_curr_r;
   logic signed [N-1:0]    x_next_r;

   logic signed [PW-1:0]   psi_s;
   logic [CW-1:0]          len_x_s;
   logic                   wr_act_s;
   logic                   wr_end_s;

   // Clamp (or sign-extend) a full-precision psi into the OW-bit result.
   function automatic logic [OW-1:0] sat_fn(input logic signed [PW-1:0] p);
      logic [OW-1:0] r;
      if (OW >= PW) begin
         r = OW'(p);
      end else if (p > SMAX) begin
         r = OW'(SMAX);
      end else if (p < SMIN) begin
         r = OW'(SMIN);
      end else begin
         r = OW'(p);
      end
      return r;
   endfunction

   // NEO kernel and write-window decode for the current run cycle.
   always_comb begin
      psi_s    = PW'(x_curr_r) * PW'(x_curr_r) - PW'(x_prev_r) * PW'(x_next_r);
      len_x_s  = CW'(len_r);
      wr_act_s = 1'b0;
      wr_end_s = 1'b0;
      // The write for address j is prepared in cycle j+4 and issued in j+5.
      if ((cyc_r >= CW'(4)) && (cyc_r <= len_x_s + CW'(3))) begin
         wr_act_s = 1'b1;
         wr_end_s = (cyc_r == CW'(4)) || (cyc_r == len_x_s + CW'(3));
      end else begin
         wr_act_s = 1'b0;
         wr_end_s = 1'b0;
      end
   end

   // Control FSM, read/write sequencing, sample pipeline and status registers.
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         state_r   <= IDLE;
         len_r     <= '0;
         thresh_r  <= '0;
         cyc_r     <= '0;
         rvalid_r  <= 1'b0;
         x_prev_r  <= '0;
         x_curr_r  <= '0;
         x_next_r  <= '0;
         raddr     <= '0;
         ren       <= 1'b0;
         waddr     <= '0;
         wdata     <= '0;
         wen       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         spike_cnt <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               ren      <= 1'b0;
               wen      <= 1'b0;
               done     <= 1'b0;
               rvalid_r <= 1'b0;
               if (start) begin
                  len_r     <= len;
                  thresh_r  <= $signed(thresh);
                  spike_cnt <= '0;
                  if ((len >= LEN_MIN) && (len <= LEN_MAX)) begin
                     err     <= 1'b0;
                     busy    <= 1'b1;
                     cyc_r   <= CW'(1);
                     ren     <= 1'b1;
                     raddr   <= '0;
                     state_r <= READ;
                  end else begin
                     // Illegal length: report and finish without any access.
                     err     <= 1'b1;
                     done    <= 1'b1;
                     state_r <= DONE;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            READ, DRAIN: begin
               cyc_r    <= cyc_r + CW'(1);
               rvalid_r <= ren;
               if (rvalid_r) begin
                  x_prev_r <= x_curr_r;
                  x_curr_r <= x_next_r;
                  x_next_r <= $signed(rdata);
               end else begin
                  x_prev_r <= x_prev_r;
               end
               // Read address k goes out in cycle k+1.
               if (cyc_r < len_x_s) begin
                  ren   <= 1'b1;
                  raddr <= AW'(cyc_r);
               end else begin
                  ren   <= 1'b0;
               end
               if (wr_act_s) begin
                  wen   <= 1'b1;
                  waddr <= AW'(cyc_r - CW'(4));
                  if (wr_end_s) begin
                     wdata <= '0;
                  end else begin
                     wdata <= sat_fn(psi_s);
                     if (psi_s > thresh_r) begin
                        spike_cnt <= spike_cnt + (AW+1)'(1);
                     end else begin
                        spike_cnt <= spike_cnt;
                     end
                  end
               end else begin
                  wen <= 1'b0;
               end
               if (cyc_r == len_x_s + CW'(4)) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_r <= DONE;
               end else if ((state_r == READ) && (cyc_r == len_x_s)) begin
                  state_r <= DRAIN;
               end else begin
                  state_r <= state_r;
               end
            end
            DONE: begin
               ren     <= 1'b0;
               wen     <= 1'b0;
               done    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               ren     <= 1'b0;
               wen     <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_neo_stream.sv
// Testbench for neo_stream: directed and randomized runs checked against a
// behavioural NEO model computed from the sample memory contents.
module tb_neo_stream;
   localparam int N  = 8;
   localparam int M  = 16;
   localparam int AW = 4;

   logic          Clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [AW:0]   len = '0;
   logic [2*N:0]  thresh = '0;
   logic [N-1:0]  rdata = '0;
   logic [AW-1:0] raddr, waddr, raddr_s, waddr_s;
   logic          ren, wen, busy, done, err;
   logic          ren_s, wen_s, busy_s, done_s, err_s;
   logic [16:0]   wdata;
   logic [11:0]   wdata_s;
   logic [AW:0]   spike_cnt, spike_cnt_s;

   neo_stream #(.N(N), .M(M)) dut (
      .Clk(Clk), .reset(reset), .start(start), .len(len), .thresh(thresh),
      .rdata(rdata), .raddr(raddr), .ren(ren), .waddr(waddr), .wdata(wdata),
      .wen(wen), .busy(busy), .done(done), .err(err), .spike_cnt(spike_cnt));

   neo_stream #(.N(N), .M(M), .OW(12)) dut_sat (
      .Clk(Clk), .reset(reset), .start(start), .len(len), .thresh(thresh),
      .rdata(rdata), .raddr(raddr_s), .ren(ren_s), .waddr(waddr_s), .wdata(wdata_s),
      .wen(wen_s), .busy(busy_s), .done(done_s), .err(err_s), .spike_cnt(spike_cnt_s));

   always #5 Clk = ~Clk;

   int tick = 0;
   always @(posedge Clk) tick <= tick + 1;

   // Source memory: synchronous read, data one cycle after ren.
   logic [N-1:0] mem [M];
   always @(posedge Clk) if (ren) rdata <= mem[raddr];

   int compared = 0;
   int mismatched = 0;
   int c0 = 0, rel = 0;
   bit mon_en = 1'b0;
   int wr_addr[$], wr_data[$], wr_sat[$], wr_cyc[$];
   int ren_n, ren_bad, busy_n, busy_first, busy_last, done_n, done_cyc;

   task automatic chk(input string tag, input int obs, input int exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_rec();
      wr_addr.delete(); wr_data.delete(); wr_sat.delete(); wr_cyc.delete();
      ren_n = 0; ren_bad = 0; busy_n = 0; busy_first = -1; busy_last = -1;
      done_n = 0; done_cyc = -1;
   endtask

   // Advance to the next falling edge and record what the DUT shows there.
   task automatic step();
      @(negedge Clk);
      rel = tick - c0;
      if (mon_en) begin
         if (wen) begin
            wr_addr.push_back(int'(waddr));
            wr_data.push_back(int'($signed(wdata)));
            wr_sat.push_back(int'($signed(wdata_s)));
            wr_cyc.push_back(rel);
         end
         if (ren) begin
            ren_n++;
            if (int'(raddr) != rel - 1) ren_bad++;
         end
         if (busy) begin
            busy_n++;
            if (busy_first < 0) busy_first = rel;
            busy_last = rel;
         end
         if (done) begin
            done_n++;
            done_cyc = rel;
         end
      end
   endtask

   function automatic int smp(input int k);
      return int'($signed(mem[k]));
   endfunction

   function automatic int psi_ref(input int ln, input int j);
      if (j == 0 || j == ln - 1) return 0;
      return smp(j) * smp(j) - smp(j - 1) * smp(j + 1);
   endfunction

   function automatic int sat12(input int p);
      if (p > 2047) return 2047;
      if (p < -2048) return -2048;
      return p;
   endfunction

   // Launch from a falling edge and follow the run until one cycle after done.
   task automatic launch(input int ln, input int th);
      clear_rec();
      start = 1'b1; len = ln[AW:0]; thresh = th[2*N:0];
      c0 = tick; mon_en = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (done_n > 0 && rel > done_cyc) break;
         step();
      end
   endtask

   task automatic verify(input int ln, input int th);
      int sp = 0;
      int p;
      chk("done_count", done_n, 1);
      chk("done_cycle", done_cyc, ln + 5);
      chk("busy_cycles", busy_n, ln + 4);
      chk("busy_first", busy_first, 1);
      chk("busy_last", busy_last, ln + 4);
      chk("ren_count", ren_n, ln);
      chk("raddr_seq", ren_bad, 0);
      chk("write_count", wr_addr.size(), ln);
      for (int j = 0; j < ln && j < wr_addr.size(); j++) begin
         p = psi_ref(ln, j);
         chk("waddr", wr_addr[j], j);
         chk("wcycle", wr_cyc[j], 5 + j);
         chk("wdata", wr_data[j], p);
         chk("wdata_sat12", wr_sat[j], sat12(p));
         if (j != 0 && j != ln - 1 && p > th) sp++;
      end
      chk("spike_cnt", int'(spike_cnt), sp);
      chk("err_clear", int'(err), 0);
   endtask

   task automatic err_run(input int ln);
      launch(ln, 0);
      chk("err_done_count", done_n, 1);
      chk("err_done_cycle", done_cyc, 1);
      chk("err_ren", ren_n, 0);
      chk("err_wen", wr_addr.size(), 0);
      chk("err_busy", busy_n, 0);
      chk("err_flag", int'(err), 1);
      chk("err_spike", int'(spike_cnt), 0);
   endtask

   task automatic load_req36();
      for (int k = 0; k < M; k++) mem[k] = '0;
      mem[1] = 8'sd3; mem[2] = 8'sd4; mem[3] = 8'sd3;
   endtask

   task automatic load_rand();
      for (int k = 0; k < M; k++) mem[k] = 8'($urandom_range(0, 255));
   endtask

   initial begin
      int ln, th, wn, rn;
      for (int k = 0; k < M; k++) mem[k] = '0;
      // Reset state.
      step(); step();
      chk("rst_ctrl", int'({ren, wen, busy, done, err}), 0);
      chk("rst_raddr", int'(raddr), 0);
      chk("rst_waddr", int'(waddr), 0);
      chk("rst_wdata", int'(wdata), 0);
      chk("rst_spike", int'(spike_cnt), 0);
      reset = 1'b1;
      step();

      // Reference example with two thresholds.
      load_req36();
      launch(5, 8);
      verify(5, 8);
      chk("req36_spike_t8", int'(spike_cnt), 2);
      // Illegal lengths, then a legal run clears err.
      err_run(2);
      err_run(17);
      launch(5, -1);
      verify(5, -1);
      chk("req36_spike_tm1", int'(spike_cnt), 3);

      // Extreme samples, full width and 12-bit saturation.
      mem[0] = 8'sd127; mem[1] = -8'sd128; mem[2] = 8'sd127;
      launch(3, 0);
      verify(3, 0);
      mem[0] = -8'sd128; mem[1] = -8'sd128; mem[2] = 8'sd127;
      launch(3, 0);
      verify(3, 0);
      if (wr_data.size() > 1) begin
         chk("req37_full", wr_data[1], 32640);
         chk("req37_sat12", wr_sat[1], 2047);
      end else begin
         chk("req37_writes", wr_data.size(), 3);
      end

      // Randomized runs, including full length.
      for (int r = 0; r < 6; r++) begin
         ln = (r == 0) ? M : int'($urandom_range(3, M));
         th = int'($urandom_range(0, 40000)) - 20000;
         load_rand();
         launch(ln, th);
         verify(ln, th);
      end

      // Reset in the middle of a full-length run.
      load_rand();
      clear_rec();
      start = 1'b1; len = 5'd16; thresh = '0; c0 = tick; mon_en = 1'b1;
      step();
      start = 1'b0;
      while (rel < 8) step();
      reset = 1'b0;
      #1;
      chk("midrst_ctrl", int'({ren, wen, busy, done, err}), 0);
      chk("midrst_raddr", int'(raddr), 0);
      chk("midrst_waddr", int'(waddr), 0);
      chk("midrst_wdata", int'(wdata), 0);
      chk("midrst_spike", int'(spike_cnt), 0);
      wn = wr_addr.size();
      rn = ren_n;
      step(); step(); step();
      reset = 1'b1;
      for (int i = 0; i < 20; i++) step();
      chk("midrst_no_writes", wr_addr.size(), wn);
      chk("midrst_no_reads", ren_n, rn);
      load_req36();
      launch(5, 8);
      verify(5, 8);

      // start held high through a len=4 run.
      load_rand();
      th = 0;
      clear_rec();
      start = 1'b1; len = 5'd4; thresh = '0; c0 = tick; mon_en = 1'b1;
      for (int i = 0; i < 40 && rel < 21; i++) begin
         step();
         if (rel == 9)  chk("hold_done", int'(done), 1);
         if (rel == 10) chk("hold_idle_busy", int'({busy, done}), 0);
         if (rel == 11) chk("hold_second_accept", int'({busy, ren, raddr}), 32'h30);
         if (rel == 9)  chk("hold_single_run", done_n, 1);
         if (rel == 12) start = 1'b0;
      end
      chk("hold_done_total", done_n, 2);
      chk("hold_ren_total", ren_n, 8);
      chk("hold_writes", wr_addr.size(), 8);
      for (int j = 0; j < 4 && j < wr_data.size(); j++) begin
         chk("hold_wdata", wr_data[j], psi_ref(4, j));
         chk("hold_wcycle", wr_cyc[j], 5 + j);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
